// File: rtl/vme_regbank_pkg.sv
// Shared constants, address classification and byte-lane helpers for the VME register bank.
package vme_regbank_pkg;

    localparam int VME_DW    = 32;
    localparam int VME_LANES = VME_DW / 8;

    typedef enum logic [1:0] {
        RW_HIT   = 2'd0,
        RO_HIT   = 2'd1,
        UNMAPPED = 2'd2
    } addr_class_e;

    typedef struct packed {
        addr_class_e cls;
        logic [31:0] idx;
    } decode_t;

    // RW registers occupy the bottom of the map, status words follow directly above.
    function automatic decode_t decode(input logic [31:0] addr, input int num_rw, input int num_ro);
        decode_t d;
        d.cls = UNMAPPED;
        d.idx = '0;
        if (addr < 32'(num_rw)) begin
            d.cls = RW_HIT;
            d.idx = addr;
        end else if (addr < 32'(num_rw + num_ro)) begin
            d.cls = RO_HIT;
            d.idx = addr - 32'(num_rw);
        end
        return d;
    endfunction

    function automatic logic [VME_DW-1:0] byte_mask(input logic [VME_LANES-1:0] sel, input int reg_w);
        logic [VME_DW-1:0] m;
        m = '0;
        for (int k = 0; k < VME_LANES; k++) begin
            if (sel[k] && (k < (reg_w + 7) / 8)) begin
                m[8*k +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/vme_regbank_if.sv
// VME slave-core side of the register bank: request pulses in, acknowledges and read data out.
interface vme_regbank_if #(
    parameter int AW = 8
);
    import vme_regbank_pkg::*;

    logic [AW-1:0]        addr;
    logic                 rd_mem;
    logic                 wr_mem;
    logic [VME_DW-1:0]    wr_data;
    logic [VME_LANES-1:0] sel;
    logic [VME_DW-1:0]    rd_data;
    logic                 rd_done;
    logic                 wr_done;
    logic                 rd_err;
    logic                 wr_err;

    modport master (
        output addr, rd_mem, wr_mem, wr_data, sel,
        input  rd_data, rd_done, wr_done, rd_err, wr_err
    );

    modport slave (
        input  addr, rd_mem, wr_mem, wr_data, sel,
        output rd_data, rd_done, wr_done, rd_err, wr_err
    );

endinterface

// File: rtl/vme_regbank_stage.sv
// Optional pipeline register with synchronous active-low clear; EN=0 collapses it to a wire.
module vme_regbank_stage
    import vme_regbank_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int EN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (EN != 0) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end else begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end

endmodule

// File: rtl/vme_regbank.sv
// VME register bank: NUM_RW byte-writable control registers, NUM_RO read-only status words,
// error acknowledge on unmapped addresses, optional input/output pipeline stages.
module vme_regbank
    import vme_regbank_pkg::*;
#(
    parameter int                      AW       = 8,
    parameter int                      NUM_RW   = 4,
    parameter int                      NUM_RO   = 2,
    parameter int                      REG_W    = 16,
    parameter logic [NUM_RW*REG_W-1:0] RW_RST   = '0,
    parameter int                      PIPE_IN  = 1,
    parameter int                      PIPE_OUT = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    vme_regbank_if.slave                                   vme,
    output logic [NUM_RW*REG_W-1:0]                        regs_o,
    output logic [NUM_RW-1:0]                              wr_stb_o,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*VME_DW-1:0]  status_i,
    output logic [((NUM_RO > 0) ? NUM_RO : 1)-1:0]         rd_stb_o
);

    localparam int IN_W  = 2 + AW + VME_DW + VME_LANES;
    localparam int OUT_W = 2 + VME_DW;

    logic [IN_W-1:0]      in_d;
    logic [IN_W-1:0]      in_q;
    logic                 rd_s;
    logic                 wr_s;
    logic [AW-1:0]        addr_s;
    logic [VME_DW-1:0]    wdata_s;
    logic [VME_LANES-1:0] sel_s;

    assign in_d = {vme.rd_mem, vme.wr_mem, vme.addr, vme.wr_data, vme.sel};

    vme_regbank_stage #(
        .WIDTH (IN_W),
        .EN    (PIPE_IN)
    ) u_in_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_d),
        .q     (in_q)
    );

    assign {rd_s, wr_s, addr_s, wdata_s, sel_s} = in_q;

    // Gating with rst_n keeps a combinational (PIPE_IN=0) request from acking during reset.
    logic    rd_req;
    logic    wr_req;
    logic    wr_hit;
    decode_t dec;

    assign rd_req = rd_s & rst_n;
    assign wr_req = wr_s & rst_n;
    assign dec    = decode(32'(addr_s), NUM_RW, NUM_RO);
    assign wr_hit = wr_req && (dec.cls == RW_HIT);

    logic [VME_DW-1:0] wmask_full;
    logic [REG_W-1:0]  wmask;

    assign wmask_full = byte_mask(sel_s, REG_W);
    assign wmask      = wmask_full[REG_W-1:0];

    logic [REG_W-1:0]  regs_q [NUM_RW];
    logic [NUM_RW-1:0] wr_stb_q;
    logic              wr_done_q;
    logic              wr_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= RW_RST[i*REG_W +: REG_W];
            end
            wr_stb_q  <= '0;
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            wr_done_q <= wr_req;
            wr_err_q  <= wr_req && (dec.cls != RW_HIT);
            for (int i = 0; i < NUM_RW; i++) begin
                wr_stb_q[i] <= wr_hit && (dec.idx == 32'(i));
                if (wr_hit && (dec.idx == 32'(i))) begin
                    regs_q[i] <= (regs_q[i] & ~wmask) | (wdata_s[REG_W-1:0] & wmask);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_regs_out
        assign regs_o[g*REG_W +: REG_W] = regs_q[g];
    end

    assign wr_stb_o    = wr_stb_q;
    assign vme.wr_done = wr_done_q;
    assign vme.wr_err  = wr_err_q;

    // Read mux sees regs_q before any same-cycle write lands, so a colliding read gets the old value.
    logic [VME_DW-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (rd_req) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if ((dec.cls == RW_HIT) && (dec.idx == 32'(i))) begin
                    rd_mux[REG_W-1:0] = regs_q[i];
                end
            end
            for (int j = 0; j < NUM_RO; j++) begin
                if ((dec.cls == RO_HIT) && (dec.idx == 32'(j))) begin
                    rd_mux = status_i[j*VME_DW +: VME_DW];
                end
            end
        end
    end

    if (NUM_RO > 0) begin : g_rd_stb
        for (genvar j = 0; j < NUM_RO; j++) begin : g_stb
            assign rd_stb_o[j] = rd_req && (dec.cls == RO_HIT) && (dec.idx == 32'(j));
        end
    end else begin : g_no_ro
        assign rd_stb_o = '0;
    end

    logic              rd_err_d;
    logic [VME_DW-1:0] rd_data_d;
    logic [VME_DW-1:0] rd_hold;
    logic [OUT_W-1:0]  out_d;
    logic [OUT_W-1:0]  out_q;

    assign rd_err_d  = rd_req && (dec.cls == UNMAPPED);
    assign rd_data_d = rd_req ? rd_mux : rd_hold;
    assign out_d     = {rd_req, rd_err_d, rd_data_d};

    vme_regbank_stage #(
        .WIDTH (OUT_W),
        .EN    (PIPE_OUT)
    ) u_out_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (out_d),
        .q     (out_q)
    );

    // Registered output recirculates its last value between reads; the unregistered one idles at 0.
    if (PIPE_OUT != 0) begin : g_hold
        assign rd_hold = out_q[VME_DW-1:0];
    end else begin : g_no_hold
        assign rd_hold = '0;
    end

    assign vme.rd_done = out_q[OUT_W-1];
    assign vme.rd_err  = out_q[OUT_W-2];
    assign vme.rd_data = out_q[VME_DW-1:0];

    logic unused_ok;
    assign unused_ok = ^{wmask_full, wdata_s};

endmodule

// File: tb/tb_vme_regbank.sv
// Directed bench: one pipelined (PIPE_IN=1, PIPE_OUT=1) and one unpipelined bank side by side.
module tb_vme_regbank;
    import vme_regbank_pkg::*;

    localparam logic [63:0] RST  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    localparam logic [63:0] STAT = {32'hCAFEF00D, 32'h12345678};

    typedef struct packed {
        logic        rd_done;
        logic        wr_done;
        logic        rd_err;
        logic        wr_err;
        logic [31:0] rd_data;
        logic [63:0] regs;
        logic [3:0]  wstb;
        logic [1:0]  rstb;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vme_regbank_if #(.AW(8)) ifp ();
    vme_regbank_if #(.AW(8)) ifc ();

    logic [63:0] regs_p, regs_c;
    logic [3:0]  wstb_p, wstb_c;
    logic [1:0]  rstb_p, rstb_c;
    logic [63:0] status;

    assign status = STAT;

    vme_regbank #(
        .AW(8), .NUM_RW(4), .NUM_RO(2), .REG_W(16), .RW_RST(RST), .PIPE_IN(1), .PIPE_OUT(1)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .vme(ifp), .regs_o(regs_p),
        .wr_stb_o(wstb_p), .status_i(status), .rd_stb_o(rstb_p)
    );

    vme_regbank #(
        .AW(8), .NUM_RW(4), .NUM_RO(2), .REG_W(16), .RW_RST(RST), .PIPE_IN(0), .PIPE_OUT(0)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .vme(ifc), .regs_o(regs_c),
        .wr_stb_o(wstb_c), .status_i(status), .rd_stb_o(rstb_c)
    );

    obs_t op, oc;
    assign op = {ifp.rd_done, ifp.wr_done, ifp.rd_err, ifp.wr_err, ifp.rd_data, regs_p, wstb_p, rstb_p};
    assign oc = {ifc.rd_done, ifc.wr_done, ifc.rd_err, ifc.wr_err, ifc.rd_data, regs_c, wstb_c, rstb_c};

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drv(input bit c, input bit rd, input bit wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        if (c) begin
            ifc.rd_mem = rd; ifc.wr_mem = wr; ifc.addr = a; ifc.wr_data = d; ifc.sel = s;
        end else begin
            ifp.rd_mem = rd; ifp.wr_mem = wr; ifp.addr = a; ifp.wr_data = d; ifp.sel = s;
        end
    endtask

    // c=1 selects the unpipelined bank; request goes out on a falling edge, samples 1 time unit later.
    task automatic rd_chk(input bit c, input logic [7:0] a, input logic [31:0] exp_d,
                          input logic exp_e, input logic [1:0] exp_stb);
        int   lat    = c ? 0 : 2;
        int   stb_at = c ? 0 : 1;
        obs_t v;
        @(negedge clk);
        drv(c, 1'b1, 1'b0, a, 32'h0, 4'h0);
        for (int k = 0; k <= lat + 1; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == 1) drv(c, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
            end
            #1;
            v = c ? oc : op;
            check($sformatf("rd_done c=%0d a=%0h k=%0d", c, a, k), 64'(v.rd_done), 64'(k == lat));
            check($sformatf("rd_stb c=%0d a=%0h k=%0d", c, a, k), 64'(v.rstb),
                  64'((k == stb_at) ? exp_stb : 2'b00));
            if (k == lat) begin
                check($sformatf("rd_data c=%0d a=%0h", c, a), 64'(v.rd_data), 64'(exp_d));
                check($sformatf("rd_err c=%0d a=%0h", c, a), 64'(v.rd_err), 64'(exp_e));
            end
            if (k == lat + 1)
                check($sformatf("rd_idle_data c=%0d a=%0h", c, a), 64'(v.rd_data), c ? 64'h0 : 64'(exp_d));
        end
    endtask

    task automatic wr_chk(input bit c, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic exp_e, input logic [3:0] exp_stb);
        int   lat = c ? 1 : 2;
        obs_t v;
        @(negedge clk);
        drv(c, 1'b0, 1'b1, a, d, s);
        for (int k = 0; k <= lat + 1; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == 1) drv(c, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
            end
            #1;
            v = c ? oc : op;
            check($sformatf("wr_done c=%0d a=%0h k=%0d", c, a, k), 64'(v.wr_done), 64'(k == lat));
            check($sformatf("wr_stb c=%0d a=%0h k=%0d", c, a, k), 64'(v.wstb),
                  64'((k == lat) ? exp_stb : 4'b0000));
            if (k == lat)
                check($sformatf("wr_err c=%0d a=%0h", c, a), 64'(v.wr_err), 64'(exp_e));
        end
    endtask

    logic [31:0] exp_rst [4] = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};
    logic [8:0]  done_seen;

    initial begin
        drv(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        drv(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        #1;
        check("rst regs p", regs_p, 64'h4444_3333_2222_1111);
        check("rst regs c", regs_c, 64'h4444_3333_2222_1111);
        check("rst acks p", 64'({op.rd_done, op.wr_done, op.rd_err, op.wr_err}), 64'h0);
        check("rst data p", 64'(op.rd_data), 64'h0);
        check("rst strobes p", 64'({op.wstb, op.rstb}), 64'h0);
        check("rst acks c", 64'({oc.rd_done, oc.wr_done, oc.rd_err, oc.wr_err}), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) rd_chk(1'b0, 8'(i), exp_rst[i], 1'b0, 2'b00);

        wr_chk(1'b0, 8'd1, 32'hDEADBEEF, 4'b0001, 1'b0, 4'b0010);
        check("reg1 after byte write p", 64'(regs_p[31:16]), 64'h22EF);
        rd_chk(1'b0, 8'd1, 32'h000022EF, 1'b0, 2'b00);

        wr_chk(1'b0, 8'd2, 32'hFFFFFFFF, 4'b0000, 1'b0, 4'b0100);
        check("reg2 sel none p", 64'(regs_p[47:32]), 64'h3333);

        wr_chk(1'b0, 8'd3, 32'hAABBCCDD, 4'b1111, 1'b0, 4'b1000);
        check("reg3 upper lanes ignored p", 64'(regs_p[63:48]), 64'hCCDD);
        rd_chk(1'b0, 8'd3, 32'h0000CCDD, 1'b0, 2'b00);

        rd_chk(1'b0, 8'd5, 32'hCAFEF00D, 1'b0, 2'b10);
        rd_chk(1'b0, 8'd4, 32'h12345678, 1'b0, 2'b01);

        wr_chk(1'b0, 8'd4, 32'h12345678, 4'b1111, 1'b1, 4'b0000);
        wr_chk(1'b0, 8'd6, 32'h12345678, 4'b1111, 1'b1, 4'b0000);
        check("regs after err writes p", regs_p, 64'hCCDD_3333_22EF_1111);
        rd_chk(1'b0, 8'hFF, 32'h0, 1'b1, 2'b00);
        rd_chk(1'b0, 8'd6, 32'h0, 1'b1, 2'b00);

        for (int i = 0; i < 4; i++) rd_chk(1'b1, 8'(i), exp_rst[i], 1'b0, 2'b00);
        wr_chk(1'b1, 8'd1, 32'hDEADBEEF, 4'b0001, 1'b0, 4'b0010);
        check("reg1 after byte write c", 64'(regs_c[31:16]), 64'h22EF);
        rd_chk(1'b1, 8'd1, 32'h000022EF, 1'b0, 2'b00);
        rd_chk(1'b1, 8'd5, 32'hCAFEF00D, 1'b0, 2'b10);
        rd_chk(1'b1, 8'hFF, 32'h0, 1'b1, 2'b00);

        @(negedge clk);
        drv(1'b1, 1'b1, 1'b1, 8'd0, 32'h00009999, 4'b0011);
        #1;
        check("collide rd_done c", 64'(oc.rd_done), 64'h1);
        check("collide rd_data c", 64'(oc.rd_data), 64'h1111);
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        #1;
        check("collide wr_done c", 64'(oc.wr_done), 64'h1);
        check("collide reg0 c", 64'(regs_c[15:0]), 64'h9999);

        done_seen = '0;
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b1, 8'd0, 32'h00005555, 4'b0011);
        #1 done_seen[0] = op.wr_done;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            case (k)
                1: drv(1'b0, 1'b0, 1'b1, 8'd1, 32'h00006666, 4'b0011);
                2: drv(1'b0, 1'b0, 1'b1, 8'd2, 32'h00007777, 4'b0011);
                3: begin drv(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0); rst_n = 1'b0; end
                4: rst_n = 1'b1;
                default: ;
            endcase
            #1 done_seen[k] = op.wr_done;
            if (k == 2) check("b2b reg0 p", 64'(regs_p[15:0]), 64'h5555);
            if (k == 3) check("b2b reg1 p", 64'(regs_p[31:16]), 64'h6666);
        end
        check("b2b done pattern p", 64'(done_seen), 64'b0_0000_1100);
        check("b2b regs after reset p", regs_p, 64'h4444_3333_2222_1111);
        check("b2b regs after reset c", regs_c, 64'h4444_3333_2222_1111);
        check("b2b data after reset p", 64'(op.rd_data), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
